// File: rtl/fazyrv_pkg.sv
// Shared types and constants for the FazyRV register-file access blocks.
package fazyrv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } rf_port_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Counter width for n chunk transfers; a single-chunk word still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fazyrv_chunk_sreg.sv
// Word buffer with parallel load and right shift by one chunk, new chunk entering at the MSB end.
module fazyrv_chunk_sreg
    import fazyrv_pkg::*;
#(
    parameter int unsigned BWIDTH = 2,
    parameter int unsigned WIDTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              shift,
    input  logic [BWIDTH-1:0] chunk_in,
    output logic [WIDTH-1:0]  q
);

    logic [WIDTH-1:0] shifted;

    generate
        if (WIDTH == BWIDTH) begin : g_single
            always_comb shifted = chunk_in;
        end else begin : g_multi
            always_comb shifted = {chunk_in, q[WIDTH-1:BWIDTH]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/fazyrv_rf_word_port.sv
// Word-wide host port: turns one 32-bit read/write into NCHUNK chunk shifts on the register file.
module fazyrv_rf_word_port
    import fazyrv_pkg::*;
#(
    parameter int unsigned BWIDTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              wr_i,
    input  logic [4:0]        addr_i,
    input  logic [31:0]       wdat_i,
    output logic              ack_o,
    output logic [31:0]       rdat_o,
    output logic              busy_o,
    output logic              shft_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rd_o,
    output logic              we_o,
    output logic [BWIDTH-1:0] res_o,
    input  logic [BWIDTH-1:0] ra_i
);

    localparam int unsigned   NCHUNK   = 32 / BWIDTH;
    localparam int unsigned   CW       = cnt_width(NCHUNK);
    localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

    rf_port_state_t state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           op;
    logic [4:0]     addr;
    logic [31:0]    wbuf, rbuf, rdat_q, rdat_done;
    logic           accept, xfer;

    assign accept = (state == IDLE) && req_i;
    assign xfer   = (state == XFER);

    fazyrv_chunk_sreg #(.BWIDTH(BWIDTH), .WIDTH(32)) u_wbuf (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (accept),
        .load_val (wdat_i),
        .shift    (xfer),
        .chunk_in ({BWIDTH{1'b0}}),
        .q        (wbuf)
    );

    fazyrv_chunk_sreg #(.BWIDTH(BWIDTH), .WIDTH(32)) u_rbuf (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (accept),
        .load_val ('0),
        .shift    (xfer),
        .chunk_in (ra_i),
        .q        (rbuf)
    );

    // Only the outgoing chunk of the write buffer is observed here.
    generate
        if (BWIDTH < 32) begin : g_wbuf_hi
            logic [31-BWIDTH:0] wbuf_hi_unused;
            assign wbuf_hi_unused = wbuf[31:BWIDTH];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= 1'b0;
            addr   <= '0;
            rdat_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op   <= wr_i;
                addr <= addr_i;
                cnt  <= '0;
            end else if (xfer && (cnt != CNT_LAST)) begin
                cnt <= cnt + CW'(1);
            end
            if ((state == DONE) && !op) begin
                rdat_q <= rdat_done;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ack_o     = 1'b0;
        busy_o    = 1'b0;
        shft_o    = 1'b0;
        we_o      = 1'b0;
        rs1_o     = '0;
        rd_o      = '0;
        res_o     = '0;
        case (state)
            IDLE: begin
                if (req_i) state_nxt = XFER;
            end
            XFER: begin
                busy_o = 1'b1;
                shft_o = 1'b1;
                rs1_o  = addr;
                rd_o   = addr;
                we_o   = op && (addr != REG_ZERO);
                res_o  = wbuf[BWIDTH-1:0];
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                ack_o     = 1'b1;
                busy_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is presented combinationally during ack and held in rdat_q afterwards.
    assign rdat_done = (addr == REG_ZERO) ? '0 : rbuf;
    assign rdat_o    = ((state == DONE) && !op) ? rdat_done : rdat_q;

endmodule

// File: tb/tb_fazyrv_rf_word_port.sv
// Bench for fazyrv_rf_word_port at BWIDTH=2 and BWIDTH=8 against a rotating register-file model.
module tb_fazyrv_rf_word_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        rf_init;
    logic        req  [2];
    logic        wr   [2];
    logic [4:0]  addr [2];
    logic [31:0] wdat [2];
    logic        ack  [2];
    logic        busy [2];
    logic        shft [2];
    logic        we   [2];
    logic [31:0] rdat [2];
    logic [4:0]  rs1  [2];
    logic [4:0]  rd   [2];
    logic [31:0] res32[2];

    logic [31:0] mem     [2][32];
    logic [31:0] last_rd [2];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned BW = (g == 0) ? 2 : 8;
        logic [BW-1:0] res, ra;
        logic [31:0]   rf [32];

        fazyrv_rf_word_port #(.BWIDTH(BW)) dut (
            .clk_i  (clk),
            .rst_i  (rst),
            .req_i  (req[g]),
            .wr_i   (wr[g]),
            .addr_i (addr[g]),
            .wdat_i (wdat[g]),
            .ack_o  (ack[g]),
            .rdat_o (rdat[g]),
            .busy_o (busy[g]),
            .shft_o (shft[g]),
            .rs1_o  (rs1[g]),
            .rd_o   (rd[g]),
            .we_o   (we[g]),
            .res_o  (res),
            .ra_i   (ra)
        );

        assign res32[g] = 32'(res);
        assign ra       = rf[rs1[g]][BW-1:0];

        // Each shift emits the low chunk and rotates in either the write chunk or the same chunk.
        always @(posedge clk) begin
            if (rf_init) begin
                for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'hFFFF_FFFF : 32'h0;
            end else if (shft[g]) begin
                rf[rd[g]] <= (rf[rd[g]] >> BW)
                           | (32'(we[g] ? res : rf[rd[g]][BW-1:0]) << (32 - BW));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one full access from an IDLE negedge and returns at the IDLE negedge after ack.
    task automatic xfer(input int g, input bit w, input logic [4:0] a, input logic [31:0] d);
        int          bw   = (g == 0) ? 2 : 8;
        int          n    = 32 / bw;
        logic [31:0] mask = (32'd1 << bw) - 32'd1;
        logic [31:0] exp_rd;
        chk("idle_busy", 32'(busy[g]), 32'd0);
        req[g]  = 1'b1;
        wr[g]   = w;
        addr[g] = a;
        wdat[g] = d;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req[g]  = 1'b0;
                wr[g]   = 1'($urandom);
                addr[g] = 5'($urandom);
                wdat[g] = $urandom;
            end
            chk("xfer_shft", 32'(shft[g]), 32'd1);
            chk("xfer_busy", 32'(busy[g]), 32'd1);
            chk("xfer_ack",  32'(ack[g]),  32'd0);
            chk("xfer_we",   32'(we[g]),   32'(w && (a != 5'd0)));
            chk("xfer_rs1",  32'(rs1[g]),  32'(a));
            chk("xfer_rd",   32'(rd[g]),   32'(a));
            chk("xfer_res",  res32[g],     (d >> (bw * (c - 1))) & mask);
        end
        @(negedge clk);
        chk("done_ack",  32'(ack[g]),  32'd1);
        chk("done_busy", 32'(busy[g]), 32'd1);
        chk("done_shft", 32'(shft[g]), 32'd0);
        chk("done_we",   32'(we[g]),   32'd0);
        if (w) begin
            if (a != 5'd0) mem[g][a] = d;
            exp_rd = last_rd[g];
        end else begin
            exp_rd     = (a == 5'd0) ? 32'd0 : mem[g][a];
            last_rd[g] = exp_rd;
        end
        chk("ack_rdat", rdat[g], exp_rd);
        @(negedge clk);
        chk("hold_rdat", rdat[g], exp_rd);
        chk("hold_ack",  32'(ack[g]), 32'd0);
    endtask

    task automatic chk_reset(input int g);
        chk("rst_ack",  32'(ack[g]),  32'd0);
        chk("rst_busy", 32'(busy[g]), 32'd0);
        chk("rst_shft", 32'(shft[g]), 32'd0);
        chk("rst_we",   32'(we[g]),   32'd0);
        chk("rst_res",  res32[g],     32'd0);
        chk("rst_rs1",  32'(rs1[g]),  32'd0);
        chk("rst_rd",   32'(rd[g]),   32'd0);
        chk("rst_rdat", rdat[g],      32'd0);
    endtask

    initial begin
        int first_ack, second_ack;
        logic [31:0] d;
        rst     = 1'b1;
        rf_init = 1'b1;
        for (int g = 0; g < 2; g++) begin
            req[g] = 1'b0; wr[g] = 1'b0; addr[g] = '0; wdat[g] = '0;
            last_rd[g] = '0;
            for (int i = 0; i < 32; i++) mem[g][i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) chk_reset(g);
        rst     = 1'b0;
        rf_init = 1'b0;
        @(negedge clk);

        xfer(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 5'd5, 32'h0);
        xfer(0, 1'b0, 5'd5, 32'h0);
        xfer(0, 1'b1, 5'd0, 32'h1234_5678);
        xfer(0, 1'b0, 5'd0, 32'h0);

        xfer(1, 1'b1, 5'd31, 32'hA5C3_0F81);
        xfer(1, 1'b0, 5'd31, 32'h0);
        xfer(1, 1'b0, 5'd0, 32'h0);

        // req held through the first ack must start a second read right after it
        first_ack  = -1;
        second_ack = -1;
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 5'd5;
        for (int c = 1; c <= 60 && second_ack < 0; c++) begin
            @(negedge clk);
            if (ack[0]) begin
                chk("b2b_rdat", rdat[0], 32'hDEAD_BEEF);
                if (first_ack < 0) first_ack = c;
                else begin
                    second_ack = c;
                    req[0] = 1'b0;
                end
            end
        end
        req[0] = 1'b0;
        chk("b2b_first",   32'(first_ack),  32'd17);
        chk("b2b_spacing", 32'(second_ack - first_ack), 32'd18);
        last_rd[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("b2b_idle", 32'(busy[0]), 32'd0);

        // asynchronous reset in the fifth transfer cycle
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 5'd7; wdat[0] = 32'hCAFE_F00D;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            req[0] = 1'b0;
        end
        chk("pre_rst_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset(0);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy[0]), 32'd0);
        xfer(0, 1'b1, 5'd7, 32'h0BAD_F00D);
        xfer(0, 1'b0, 5'd7, 32'h0);

        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 30; k++) begin
                logic [4:0] a;
                case ($urandom_range(0, 3))
                    0:       a = 5'd0;
                    1:       a = 5'd31;
                    default: a = 5'($urandom_range(1, 6));
                endcase
                d = $urandom;
                xfer(g, 1'($urandom), a, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
